shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
// PURPOSE
//   Round-robin arbiter that shares one DATA_W-bit storage register (a bank of D flip-flops) among
//   NUM_REQ requesters. It grants one requester at a time and commits that requester's write data
//   into the register. A granted requester may lock the register for a bounded burst of writes.
//   The block sits between the requester logic and the register bank.
// PARAMETERS
//   NUM_REQ   4   number of requesters (>=2)
//   DATA_W    8   width of shared register and each wdata slice
//   HOLD_MAX  4   max consecutive writes one owner may perform per grant (>=1)
// PORTS
//   clock  in   1                rising-edge clock, single domain
//   reset  in   1                synchronous, active-high reset
//   req    in   NUM_REQ          req[i]=1: requester i wants to write
//   lock   in   NUM_REQ          lock[i]=1: keep grant after this write (ignored unless granted)
//   wdata  in   NUM_REQ*DATA_W   requester i data at [i*DATA_W +: DATA_W]
//   grant  out  NUM_REQ          registered, one-hot or zero
//   ack    out  NUM_REQ          registered 1-cycle pulse: write of requester i committed
//   q      out  DATA_W           shared register contents
//   owner  out  clog2(NUM_REQ)   index of last committed writer
//   busy   out  1                1 whenever grant != 0
// BEHAVIOUR
//   Reset (sync, active-high): state=IDLE, grant=0, ack=0, q=0, owner=0, busy=0, ptr=0, hold_cnt=0.
//     Reset overrides everything in the same edge; an in-flight grant is aborted, no ack issued.
//   States: IDLE, GRANT, LOCKED.
//   IDLE: if req!=0, pick first i with req[i]=1 searching ptr, ptr+1, ... mod NUM_REQ;
//     grant<=onehot(i), hold_cnt<=0, ->GRANT. If req==0, stay IDLE, outputs hold.
//   GRANT/LOCKED (grant[i]=1), evaluated each edge:
//     - req[i]=1: q<=wdata[i], owner<=i, ack[i]<=1 (pulse), hold_cnt<=hold_cnt+1.
//       If lock[i]=1 and hold_cnt+1 < HOLD_MAX: keep grant, ->LOCKED.
//       Else release: grant<=0, ptr<=(i+1) mod NUM_REQ, ->IDLE.
//     - req[i]=0: release as above, no write, no ack, q unchanged.
//   Latency: req sampled in IDLE at edge N -> grant high after N; q/ack update at edge N+1.
//   After a release there is always exactly one IDLE cycle before the next grant.
//   req/lock/wdata of non-granted requesters are ignored while busy. lock without grant is ignored.
//   ack is 0 on every cycle except the one following a committed write; at most one bit set.
//   ptr wraps NUM_REQ-1 -> 0. Starvation-free: with all req high, grants rotate 0,1,2,...
//   hold_cnt width: clog2(HOLD_MAX+1); never exceeds HOLD_MAX. HOLD_MAX=1 disables locking.
//   q changes only on a committed write or reset.
// TESTING
//   1 Reset: hold reset 2 cycles with req=4'b1111 -> grant=0, ack=0, q=0, owner=0, busy=0.
//   2 Single write: req=4'b0100, wdata[2]=8'hA5, lock=0 -> grant=4'b0100 next cycle,
//     then q=8'hA5, ack=4'b0100 for 1 cycle, owner=2, then grant=0.
//   3 Fairness/wrap: req=4'b1111 held, lock=0, wdata[i]=8'h10+i -> grant order 0,1,2,3,0
//     with one IDLE cycle between grants; q sequence 10,11,12,13,10.
//   4 Lock burst: HOLD_MAX=4, req[1]=1, lock[1]=1, wdata[1] counting 1,2,3,4,5 -> four
//     consecutive acks to 1, q ends at the 4th value, then release; req[3]=1 granted next.
//   5 Withdrawn request: grant=4'b0010 then req[1]=0 -> no ack, q unchanged, grant=0, ptr=2.
//   6 Reset mid-burst: assert reset during LOCKED -> next cycle all outputs at reset values,
//     no ack pulse; after release arbitration restarts from requester 0.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share a single DATA_W-bit
//   register. One requester is granted at a time. While granted, each cycle with
//   its req high commits its wdata slice into the register and pulses its ack bit.
//   A granted requester may hold lock to keep the grant for up to HOLD_MAX
//   consecutive writes.
//
//   Ports
//     clock  : rising-edge clock
//     reset  : synchronous, active-high reset
//     req    : per-requester write request
//     lock   : per-requester "keep grant after this write" (only the owner's bit matters)
//     wdata  : requester i data at [i*DATA_W +: DATA_W]
//     grant  : registered grant, one-hot or zero
//     ack    : registered one-cycle pulse, write of requester i committed
//     q      : shared register contents
//     owner  : index of the last committed writer
//     busy   : high whenever grant is non-zero
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no grant; round-robin search from ptr on the next edge
//   GRANT  | grant just issued, first write pending
//   LOCKED | owner kept the grant via lock, further writes pending

module shared_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*DATA_W-1:0]     wdata,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_W-1:0]             q,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [PTR_W:0]   NREQ     = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_nxt, ack_nxt;
  logic [DATA_W-1:0]  q_nxt;
  logic [PTR_W-1:0]   owner_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [PTR_W-1:0]   cur, cur_nxt;
  logic [CNT_W-1:0]   hold_cnt, hold_nxt, hold_inc;

  logic [DATA_W-1:0]  wd [NUM_REQ];
  logic               found;
  logic [PTR_W-1:0]   pick;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign wd[i] = wdata[i*DATA_W +: DATA_W];
  end

  assign busy     = |grant;
  assign hold_inc = hold_cnt + 1'b1;

  // Round-robin search: first set req bit at ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    logic [PTR_W:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ack_nxt   = '0;
    q_nxt     = q;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cur_nxt   = cur;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          cur_nxt         = pick;
          hold_nxt        = '0;
          state_nxt       = GRANT;
        end
      end
      GRANT, LOCKED: begin
        if (req[cur]) begin
          q_nxt        = wd[cur];
          owner_nxt    = cur;
          ack_nxt[cur] = 1'b1;
          hold_nxt     = hold_inc;
        end
        // A withdrawn request releases without writing; so does an unlocked
        // write or one that exhausts the burst allowance.
        if (req[cur] && lock[cur] && (hold_inc < HOLD_LIM)) begin
          state_nxt = LOCKED;
        end else begin
          grant_nxt = '0;
          ptr_nxt   = (cur == LAST_IDX) ? '0 : cur + 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      ack      <= '0;
      q        <= '0;
      owner    <= '0;
      ptr      <= '0;
      cur      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      ack      <= ack_nxt;
      q        <= q_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      cur      <= cur_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        lock;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         q;
  logic [1:0]                owner;
  logic                      busy;

  typedef struct {
    int              idx;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  shared_reg_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .HOLD_MAX(4)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .grant (grant),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expect the write (if any) queued before this edge to be acked right after it.
  task automatic push_wr(input int idx, input logic [DATA_W-1:0] data);
    wr_t w;
    w.idx  = idx;
    w.data = data;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    wr_t w;
    @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("ack_pulse", 32'(ack), 32'(1 << w.idx));
      chk("ack_q", 32'(q), 32'(w.data));
      chk("ack_owner", 32'(owner), 32'(w.idx));
    end else begin
      chk("ack_idle", 32'(ack), 32'd0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_ack"},   32'(ack),   32'd0);
    chk({tag, "_q"},     32'(q),     32'd0);
    chk({tag, "_owner"}, 32'(owner), 32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req   = '1;
    lock  = '0;
    wdata = '0;

    // 1: reset held two cycles with all requests high
    tick();
    tick();
    chk_reset_vals("rst");

    // 2: single write from requester 2
    reset = 1'b0;
    req   = 4'b0100;
    wdata[2*DATA_W +: DATA_W] = 8'hA5;
    tick();
    chk("single_grant", 32'(grant), 32'b0100);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_q_before", 32'(q), 32'd0);
    push_wr(2, 8'hA5);
    tick();
    chk("single_release", 32'(grant), 32'd0);
    req = '0;
    tick();
    chk("single_q_hold", 32'(q), 32'hA5);

    // 3: fairness and wrap from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req   = '1;
    for (int i = 0; i < NUM_REQ; i++) wdata[i*DATA_W +: DATA_W] = DATA_W'(8'h10 + i);
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(1 << (n % NUM_REQ)));
      push_wr(n % NUM_REQ, DATA_W'(8'h10 + (n % NUM_REQ)));
      tick();
      chk("rr_idle_gap", 32'(grant), 32'd0);
    end
    req = '0;

    // 4: locked burst by requester 1, then requester 3 (pointer is now 1)
    req  = 4'b1010;
    lock = 4'b0010;
    tick();
    chk("lock_grant", 32'(grant), 32'b0010);
    for (int k = 1; k <= 4; k++) begin
      wdata[1*DATA_W +: DATA_W] = DATA_W'(k);
      push_wr(1, DATA_W'(k));
      tick();
      chk("lock_grant_hold", 32'(grant), (k < 4) ? 32'b0010 : 32'd0);
    end
    wdata[1*DATA_W +: DATA_W] = 8'd5;
    wdata[3*DATA_W +: DATA_W] = 8'h33;
    lock = '0;
    tick();
    chk("lock_next_grant", 32'(grant), 32'b1000);
    chk("lock_q_final", 32'(q), 32'd4);
    push_wr(3, 8'h33);
    tick();
    req = '0;

    // 5: withdrawn request leaves q alone and advances the pointer
    req = 4'b0010;
    tick();
    chk("wd_grant", 32'(grant), 32'b0010);
    req = '0;
    tick();
    chk("wd_release", 32'(grant), 32'd0);
    chk("wd_q", 32'(q), 32'h33);
    chk("wd_owner", 32'(owner), 32'd3);
    req = '1;
    tick();
    chk("wd_ptr2", 32'(grant), 32'b0100);
    req = '0;
    tick();
    chk("wd_q2", 32'(q), 32'h33);

    // 6: reset during a locked burst (pointer is now 3)
    req  = 4'b1001;
    lock = 4'b1001;
    wdata[3*DATA_W +: DATA_W] = 8'h77;
    tick();
    chk("mid_grant", 32'(grant), 32'b1000);
    push_wr(3, 8'h77);
    tick();
    chk("mid_locked", 32'(grant), 32'b1000);
    reset = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    reset = 1'b0;
    lock  = '0;
    tick();
    chk("mid_restart", 32'(grant), 32'b0001);
    req = '0;
    tick();
    chk("mid_release", 32'(grant), 32'd0);
    chk("pending_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
